// File: rtl/timer_ctrl.sv
// Timer controller: sequences an external 8-bit counter through load/run,
// generates prescaled count ticks and turns counter overflow/underflow edges
// into flag-clear pulses, a sticky interrupt and optional auto-reload.
module timer_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       auto_reload_i,
    input  logic       dir_i,
    input  logic [1:0] cks_i,
    input  logic [7:0] start_value_i,
    input  logic       clr_irq_i,
    input  logic       ovf_in_i,
    input  logic       udf_in_i,
    output logic       cnt_clk_ena_o,
    output logic       cnt_load_o,
    output logic       cnt_enable_o,
    output logic       cnt_up_down_o,
    output logic [7:0] cnt_start_value_o,
    output logic       cnt_clr_overflow_o,
    output logic       cnt_clr_underflow_o,
    output logic       irq_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e     state_q, state_d;
    logic [3:0] presc_q, presc_d;
    logic       dir_q, auto_q;
    logic [1:0] cks_q;
    logic [7:0] sv_q;
    logic       ovf_dly_q, udf_dly_q;
    logic       clr_ovf_q, clr_udf_q;
    logic       irq_q, irq_d;

    logic       evt_ovf, evt_udf, evt_any;
    logic       cfg_latch;
    logic [4:0] mask_full;
    logic [3:0] mask;

    // Event detection, next state, prescaler and interrupt next-state.
    always_comb begin
        evt_ovf   = (state_q == StRun) && ovf_in_i && !ovf_dly_q;
        evt_udf   = (state_q == StRun) && udf_in_i && !udf_dly_q;
        evt_any   = evt_ovf || evt_udf;

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) state_d = StLoad;
            end
            StLoad: begin
                state_d = stop_i ? StIdle : StRun;
            end
            StRun: begin
                // Stop beats an event-driven reload.
                if (stop_i) begin
                    state_d = StIdle;
                end else if (evt_any) begin
                    state_d = auto_q ? StLoad : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Config is captured only when leaving IDLE; reloads reuse it.
        cfg_latch = (state_q == StIdle) && (state_d == StLoad);

        presc_d = ((state_q == StRun) && (state_d == StRun)) ? presc_q + 4'd1 : 4'd0;

        irq_d = irq_q;
        if (evt_any) begin
            irq_d = 1'b1;
        end else if (clr_irq_i) begin
            irq_d = 1'b0;
        end

        mask_full = (5'd2 << cks_q) - 5'd1;
        mask      = mask_full[3:0];
    end

    // State, configuration, prescaler, edge-detect and pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            presc_q   <= 4'd0;
            dir_q     <= 1'b0;
            auto_q    <= 1'b0;
            cks_q     <= 2'd0;
            sv_q      <= 8'd0;
            ovf_dly_q <= 1'b0;
            udf_dly_q <= 1'b0;
            clr_ovf_q <= 1'b0;
            clr_udf_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ovf_dly_q <= ovf_in_i;
            udf_dly_q <= udf_in_i;
            clr_ovf_q <= evt_ovf;
            clr_udf_q <= evt_udf;
            irq_q     <= irq_d;
            if (cfg_latch) begin
                dir_q  <= dir_i;
                auto_q <= auto_reload_i;
                cks_q  <= cks_i;
                sv_q   <= start_value_i;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        cnt_load_o          = (state_q == StLoad);
        cnt_enable_o        = (state_q == StRun);
        cnt_up_down_o       = (state_q != StIdle) && dir_q;
        cnt_start_value_o   = sv_q;
        cnt_clk_ena_o       = (state_q == StRun) && ((presc_q & mask) == mask);
        cnt_clr_overflow_o  = clr_ovf_q;
        cnt_clr_underflow_o = clr_udf_q;
        irq_o               = irq_q;
        busy_o              = (state_q != StIdle);
    end

endmodule
